// File: rtl/mmu_pkg.sv
// mmu_pkg: shared types and constants for the matrix-multiply array controller.
//   mmu_state_e   - controller FSM states
//   MMU_N         - array dimension (rows = columns = lanes)
//   MMU_DW        - bits per data/weight element
//   MMU_ACC_W     - accumulator width per lane
//   MMU_DRAIN_CYC - default zero-data cycles before the result is sampled
package mmu_pkg;

  localparam int MMU_N         = 4;
  localparam int MMU_DW        = 8;
  localparam int MMU_ACC_W     = 32;
  localparam int MMU_DRAIN_CYC = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_WT = 3'd1,
    STREAM  = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } mmu_state_e;

  // Width needed to count 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mmu_skew.sv
// mmu_skew: data-row buffer plus diagonal skew generator.
//   clk, rst          - clock, synchronous active-high reset (clears the buffer)
//   wr_en/addr/data   - write one data row (already gated to IDLE by the caller)
//   stream            - high while the controller is in STREAM
//   t                 - STREAM cycle counter
//   data_arr          - skewed array data; lane i carries row (t-i) element i
//                       when 0 <= t-i < N, otherwise zero
import mmu_pkg::*;

module mmu_skew #(
  parameter int N  = MMU_N,
  parameter int DW = MMU_DW,
  parameter int TW = $clog2(2*N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [1:0]      wr_addr,
  input  logic [N*DW-1:0] wr_data,
  input  logic            stream,
  input  logic [TW-1:0]   t,
  output logic [N*DW-1:0] data_arr
);

  localparam int AW = $clog2(N);

  logic [N-1:0][N-1:0][DW-1:0] buf_q;   // [row][lane]
  logic [N-1:0][DW-1:0]        lane;

  always_ff @(posedge clk) begin
    if (rst)        buf_q <= '0;
    else if (wr_en) buf_q[wr_addr[AW-1:0]] <= wr_data;
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [TW:0] r;   // row index t-i, one extra bit so t<i cannot alias
    always_comb begin
      r       = {1'b0, t} - (TW+1)'(i);
      lane[i] = '0;
      if (stream && ({1'b0, t} >= (TW+1)'(i)) && (r < (TW+1)'(N)))
        lane[i] = buf_q[r[AW-1:0]][i];
    end
  end

  assign data_arr = lane;

endmodule

// File: rtl/mmu_ctrl.sv
// mmu_ctrl: controller for an N x N weight-stationary systolic array.
//   clk, rst                  - clock, synchronous active-high reset
//   wt_wr_en/addr/data        - write one weight row (accepted only in IDLE)
//   dat_wr_en/addr/data       - write one data row (accepted only in IDLE)
//   start                     - begin a multiply (sampled only in IDLE)
//   busy                      - high in every state except IDLE
//   control                   - array weight-load enable (LOAD_WT)
//   wt_arr, data_arr          - array weight / skewed data inputs
//   acc_out                   - array accumulators, sampled on the last DRAIN edge
//   res_valid, res_data, done - one-cycle result strobe, held result, completion
// Optional feature: define MMU_CTRL_WT_REUSE_EN to skip LOAD_WT when no weight
// row has been written since the last load.
import mmu_pkg::*;

module mmu_ctrl #(
  parameter int N         = MMU_N,
  parameter int DW        = MMU_DW,
  parameter int DRAIN_CYC = MMU_DRAIN_CYC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wt_wr_en,
  input  logic [1:0]             wt_wr_addr,
  input  logic [N*DW-1:0]        wt_wr_data,
  input  logic                   dat_wr_en,
  input  logic [1:0]             dat_wr_addr,
  input  logic [N*DW-1:0]        dat_wr_data,
  input  logic                   start,
  output logic                   busy,
  output logic                   control,
  output logic [N*DW-1:0]        wt_arr,
  output logic [N*DW-1:0]        data_arr,
  input  logic [N*MMU_ACC_W-1:0] acc_out,
  output logic                   res_valid,
  output logic [N*MMU_ACC_W-1:0] res_data,
  output logic                   done
);

  localparam int AW = $clog2(N);
  localparam int TW = $clog2(2*N);
  localparam int CW = cnt_width((DRAIN_CYC > 2*N) ? DRAIN_CYC : 2*N);

  mmu_state_e            state;
  logic [CW-1:0]         cnt;
  logic [N-1:0][N*DW-1:0] wt_buf;
  logic                  wt_we, dat_we, load_needed;

  // Buffers only change while idle, so a running multiply sees stable rows.
  assign wt_we  = wt_wr_en  && (state == IDLE);
  assign dat_we = dat_wr_en && (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst)        wt_buf <= '0;
    else if (wt_we) wt_buf[wt_wr_addr[AW-1:0]] <= wt_wr_data;
  end

`ifdef MMU_CTRL_WT_REUSE_EN
  logic wt_dirty;
  always_ff @(posedge clk) begin
    if (rst)                                          wt_dirty <= 1'b1;
    else if (wt_we)                                   wt_dirty <= 1'b1;
    else if (state == LOAD_WT && cnt == CW'(N-1))     wt_dirty <= 1'b0;
  end
  // A write in the start cycle must still force a reload.
  assign load_needed = wt_dirty | wt_we;
`else
  assign load_needed = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      control   <= 1'b0;
      res_valid <= 1'b0;
      done      <= 1'b0;
      res_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            if (load_needed) begin
              state   <= LOAD_WT;
              control <= 1'b1;
            end else begin
              state   <= STREAM;
            end
          end
        end
        LOAD_WT: begin
          if (cnt == CW'(N-1)) begin
            state   <= STREAM;
            control <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STREAM: begin
          if (cnt == CW'(2*N-2)) begin
            state <= DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DRAIN: begin
          if (cnt == CW'(DRAIN_CYC-1)) begin
            state     <= DONE;
            cnt       <= '0;
            res_data  <= acc_out;
            res_valid <= 1'b1;
            done      <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
          done      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          control   <= 1'b0;
          res_valid <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  // Row k is presented in LOAD_WT cycle k; zero everywhere else.
  assign wt_arr = (state == LOAD_WT) ? wt_buf[cnt[AW-1:0]] : '0;

  mmu_skew #(.N(N), .DW(DW), .TW(TW)) u_skew (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (dat_we),
    .wr_addr  (dat_wr_addr),
    .wr_data  (dat_wr_data),
    .stream   (state == STREAM),
    .t        (cnt[TW-1:0]),
    .data_arr (data_arr)
  );

endmodule

// File: tb/tb_mmu_ctrl.sv
// tb_mmu_ctrl: directed self-checking bench for mmu_ctrl at default parameters.
module tb_mmu_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         wt_wr_en, dat_wr_en, start;
  logic [1:0]   wt_wr_addr, dat_wr_addr;
  logic [31:0]  wt_wr_data, dat_wr_data;
  logic         busy, control, res_valid, done;
  logic [31:0]  wt_arr, data_arr;
  logic [127:0] acc_out, res_data;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0]  wrow [4];
  logic [31:0]  drow [4];
  logic [31:0]  sexp [7];
  logic [127:0] last_res;
  bit           ld_exp;

  localparam logic [127:0] PAT_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] PAT_B = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;

  mmu_ctrl dut (
    .clk(clk), .rst(rst),
    .wt_wr_en(wt_wr_en), .wt_wr_addr(wt_wr_addr), .wt_wr_data(wt_wr_data),
    .dat_wr_en(dat_wr_en), .dat_wr_addr(dat_wr_addr), .dat_wr_data(dat_wr_data),
    .start(start), .busy(busy), .control(control),
    .wt_arr(wt_arr), .data_arr(data_arr), .acc_out(acc_out),
    .res_valid(res_valid), .res_data(res_data), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; wt_wr_en = 1'b0; dat_wr_en = 1'b0;
  endtask

  // Writes rows 0..2 of both buffers in the same cycles; row 3 rides with start.
  task automatic write_rows_012();
    for (int k = 0; k < 3; k++) begin
      wt_wr_en  = 1'b1; wt_wr_addr  = 2'(k); wt_wr_data  = wrow[k];
      dat_wr_en = 1'b1; dat_wr_addr = 2'(k); dat_wr_data = drow[k];
      @(negedge clk);
    end
    idle_inputs();
  endtask

  // One full multiply, called at a negedge in IDLE. Checks every busy cycle.
  task automatic run(input bit ld, input logic [127:0] pat, input bit inj, input bit wr_last);
    int total, so, k;
    logic [31:0] wexp, dexp;
    total   = ld ? 20 : 16;
    so      = ld ? 5 : 1;
    acc_out = pat;
    start   = 1'b1;
    if (wr_last) begin
      wt_wr_en  = 1'b1; wt_wr_addr  = 2'd3; wt_wr_data  = wrow[3];
      dat_wr_en = 1'b1; dat_wr_addr = 2'd3; dat_wr_data = drow[3];
    end
    @(negedge clk);
    idle_inputs();
    for (int c = 1; c <= total; c++) begin
      wexp = (ld && c <= 4) ? wrow[c-1] : 32'h0;
      k    = c - so;
      dexp = (k >= 0 && k < 7) ? sexp[k] : 32'h0;
      chk($sformatf("busy c%0d", c),    busy,    1'b1);
      chk($sformatf("control c%0d", c), control, (ld && c <= 4));
      chk($sformatf("wt_arr c%0d", c),  wt_arr,  wexp);
      chk($sformatf("data_arr c%0d", c), data_arr, dexp);
      chk($sformatf("done c%0d", c),    done,      (c == total));
      chk($sformatf("res_valid c%0d", c), res_valid, (c == total));
      chk($sformatf("res_data c%0d", c), res_data, (c == total) ? pat : last_res);
      if (inj && c == 3) begin
        start     = 1'b1;
        wt_wr_en  = 1'b1; wt_wr_addr  = 2'd0; wt_wr_data  = 32'hFFFF_FFFF;
        dat_wr_en = 1'b1; dat_wr_addr = 2'd1; dat_wr_data = 32'hFFFF_FFFF;
      end else begin
        idle_inputs();
      end
      @(negedge clk);
    end
    idle_inputs();
    chk("busy after done",  busy,     1'b0);
    chk("done after done",  done,     1'b0);
    chk("res_data held",    res_data, pat);
    last_res = pat;
  endtask

  initial begin
    int abort_c, n_done;
    wrow[0] = 32'h0502_0304; wrow[1] = 32'h0301_0203;
    wrow[2] = 32'h0704_0102; wrow[3] = 32'h0102_0403;
    drow[0] = 32'h0000_0001; drow[1] = 32'h0000_0100;
    drow[2] = 32'h0001_0000; drow[3] = 32'h0100_0000;
    sexp[0] = 32'h0000_0001; sexp[1] = 32'h0;
    sexp[2] = 32'h0000_0100; sexp[3] = 32'h0;
    sexp[4] = 32'h0001_0000; sexp[5] = 32'h0;
    sexp[6] = 32'h0100_0000;
`ifdef MMU_CTRL_WT_REUSE_EN
    ld_exp = 1'b0;
`else
    ld_exp = 1'b1;
`endif
    last_res = '0;
    acc_out = '0; wt_wr_addr = '0; dat_wr_addr = '0;
    wt_wr_data = '0; dat_wr_data = '0;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst busy",      busy,      1'b0);
    chk("rst control",   control,   1'b0);
    chk("rst wt_arr",    wt_arr,    32'h0);
    chk("rst data_arr",  data_arr,  32'h0);
    chk("rst res_valid", res_valid, 1'b0);
    chk("rst done",      done,      1'b0);
    chk("rst res_data",  res_data,  128'h0);

    // First run loads weights; row 3 is written in the start cycle.
    write_rows_012();
    run(1'b1, PAT_A, 1'b0, 1'b1);

    // Writes and start during busy are ignored; reuse build skips LOAD_WT.
    run(ld_exp, PAT_B, 1'b1, 1'b0);

    // Same expectations as before prove the buffers were untouched.
    run(ld_exp, PAT_A, 1'b0, 1'b0);

    // Abort in STREAM cycle 3 with reset.
    abort_c = ld_exp ? 8 : 4;
    acc_out = PAT_B;
    start = 1'b1;
    @(negedge clk);
    idle_inputs();
    for (int c = 1; c < abort_c; c++) @(negedge clk);
    chk("pre-abort busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy",      busy,      1'b0);
    chk("abort control",   control,   1'b0);
    chk("abort wt_arr",    wt_arr,    32'h0);
    chk("abort data_arr",  data_arr,  32'h0);
    chk("abort res_valid", res_valid, 1'b0);
    chk("abort done",      done,      1'b0);
    chk("abort res_data",  res_data,  128'h0);
    n_done = 0;
    for (int c = 0; c < 25; c++) begin
      if (done || busy) n_done++;
      @(negedge clk);
    end
    chk("no done after abort", n_done, 0);
    last_res = '0;

    // Buffers were cleared by reset; reload and run a complete sequence.
    write_rows_012();
    run(1'b1, PAT_B, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
